// File: rtl/exp_taylor_sequencer.sv
// exp_taylor_sequencer
//   Computes exp(x) ~= 1 + sum_{n=1..TERMS} x^n/n! in signed fixed point
//   (DATA_WIDTH bits, FRACTION fraction bits). Every product goes through one
//   external pipelined multiplier, one product in flight at a time. The adder
//   and accumulator are local.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_x   operand handshake (accepted only when idle)
//   out_valid/out_ready      result handshake; out_y/out_ovf held until taken
//   out_y, out_ovf           result and sticky saturation flag for this result
//   mult_valid, mult_a/_b    product issue (operands are 0 when not issuing)
//   mult_result(_valid)      full signed product returned by the multiplier
module exp_taylor_sequencer #(
   parameter int DATA_WIDTH = 12,
   parameter int FRACTION   = 0,
   parameter int TERMS      = 4,
   parameter int PIPE       = 4   // nominal multiplier latency; the FSM waits on valid
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [DATA_WIDTH-1:0]  in_x,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [DATA_WIDTH-1:0]  out_y,
   output logic                          out_ovf,
   output logic                          mult_valid,
   output logic signed [DATA_WIDTH-1:0]  mult_a,
   output logic signed [DATA_WIDTH-1:0]  mult_b,
   input  logic [2*DATA_WIDTH-1:0]       mult_result,
   input  logic                          mult_result_valid
);

   localparam int MAX_TERMS = 10;
   localparam int UPPER_W   = DATA_WIDTH - FRACTION + 1;

   if (TERMS < 1 || TERMS > MAX_TERMS) begin : g_bad_terms
      $error("exp_taylor_sequencer: TERMS must be in 1..10");
   end
   if (FRACTION < 0 || FRACTION >= DATA_WIDTH) begin : g_bad_fraction
      $error("exp_taylor_sequencer: FRACTION must be in 0..DATA_WIDTH-1");
   end
   if (PIPE < 1) begin : g_bad_pipe
      $error("exp_taylor_sequencer: multiplier latency must be at least 1");
   end

   localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // Positive constants only; clamp to the signed maximum when they do not fit.
   function automatic logic signed [DATA_WIDTH-1:0] sat_const(input longint v);
      longint vmax;
      vmax = (longint'(1) << (DATA_WIDTH - 1)) - 1;
      return (v > vmax) ? S_MAX : DATA_WIDTH'(v);
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] recip_const(input int n);
      longint fact;
      if (n < 1 || n > MAX_TERMS) return '0;
      fact = 1;
      for (int i = 2; i <= n; i++) fact = fact * longint'(i);
      return sat_const((longint'(1) << FRACTION) / fact);
   endfunction

   localparam logic signed [DATA_WIDTH-1:0] ONE = sat_const(longint'(1) << FRACTION);

   // 16 entries so the 4-bit term index addresses the table exactly.
   logic signed [DATA_WIDTH-1:0] recip_rom [16];
   for (genvar g = 0; g < 16; g++) begin : g_recip
      assign recip_rom[g] = recip_const(g);
   end

   typedef enum logic [2:0] {
      StIdle, StMulPow, StWaitPow, StMulTerm, StWaitTerm, StDone
   } state_e;

   state_e                        state_q, state_d;
   logic signed [DATA_WIDTH-1:0]  x_q, x_d;
   logic signed [DATA_WIDTH-1:0]  pow_q, pow_d;
   logic signed [DATA_WIDTH-1:0]  acc_q, acc_d;
   logic [3:0]                    n_q, n_d;
   logic                          ovf_q, ovf_d;
   logic                          started_q, started_d;

   // Truncate the product back to DATA_WIDTH, saturating when the discarded
   // upper bits are not a pure sign extension.
   logic [UPPER_W-1:0]            upper;
   logic signed [DATA_WIDTH-1:0]  trunc_val;
   logic                          trunc_ovf;
   logic                          unused_mult_lsbs;

   assign unused_mult_lsbs = ^mult_result;

   always_comb begin
      upper     = mult_result[2*DATA_WIDTH-1 -: UPPER_W];
      trunc_val = mult_result[DATA_WIDTH+FRACTION-1 : FRACTION];
      trunc_ovf = 1'b0;
      if (!((&upper) || !(|upper))) begin
         trunc_val = mult_result[2*DATA_WIDTH-1] ? S_MIN : S_MAX;
         trunc_ovf = 1'b1;
      end
   end

   // One-bit-wider accumulate; disagreement of the top two bits means overflow.
   logic signed [DATA_WIDTH:0]    sum_wide;
   logic signed [DATA_WIDTH-1:0]  sum_sat;
   logic                          sum_ovf;

   always_comb begin
      sum_wide = {acc_q[DATA_WIDTH-1], acc_q} + {trunc_val[DATA_WIDTH-1], trunc_val};
      sum_sat  = sum_wide[DATA_WIDTH-1:0];
      sum_ovf  = 1'b0;
      if (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]) begin
         sum_sat = sum_wide[DATA_WIDTH] ? S_MIN : S_MAX;
         sum_ovf = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         x_q       <= '0;
         pow_q     <= '0;
         acc_q     <= '0;
         n_q       <= '0;
         ovf_q     <= 1'b0;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         pow_q     <= pow_d;
         acc_q     <= acc_d;
         n_q       <= n_d;
         ovf_q     <= ovf_d;
         started_q <= started_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      pow_d     = pow_q;
      acc_d     = acc_q;
      n_d       = n_q;
      ovf_d     = ovf_q;
      started_d = 1'b1;
      unique case (state_q)
         StIdle: begin
            if (in_valid && started_q) begin
               x_d     = in_x;
               pow_d   = ONE;
               acc_d   = ONE;
               n_d     = 4'd1;
               ovf_d   = 1'b0;
               state_d = StMulPow;
            end
         end
         StMulPow:  state_d = StWaitPow;
         StWaitPow: begin
            if (mult_result_valid) begin
               pow_d   = trunc_val;
               ovf_d   = ovf_q | trunc_ovf;
               state_d = StMulTerm;
            end
         end
         StMulTerm: state_d = StWaitTerm;
         StWaitTerm: begin
            if (mult_result_valid) begin
               acc_d = sum_sat;
               ovf_d = ovf_q | trunc_ovf | sum_ovf;
               if (n_q == 4'(TERMS)) begin
                  state_d = StDone;
               end else begin
                  n_d     = n_q + 4'd1;
                  state_d = StMulPow;
               end
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from registered state only, so reset zeroes them at once.
   always_comb begin
      in_ready   = started_q && (state_q == StIdle);
      out_valid  = 1'b0;
      out_y      = '0;
      out_ovf    = 1'b0;
      mult_valid = 1'b0;
      mult_a     = '0;
      mult_b     = '0;
      unique case (state_q)
         StMulPow: begin
            mult_valid = 1'b1;
            mult_a     = pow_q;
            mult_b     = x_q;
         end
         StMulTerm: begin
            mult_valid = 1'b1;
            mult_a     = pow_q;
            mult_b     = recip_rom[n_q];
         end
         StDone: begin
            out_valid = 1'b1;
            out_y     = acc_q;
            out_ovf   = ovf_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_exp_taylor_sequencer.sv
// Bench for exp_taylor_sequencer at DATA_WIDTH=12, FRACTION=9, TERMS=4 with a
// variable-latency multiplier model and an arithmetic reference of the series.
module tb_exp_taylor_sequencer;

   localparam int DW = 12;
   localparam int FR = 9;
   localparam int TM = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic signed [DW-1:0]  in_x = '0;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic signed [DW-1:0]  out_y;
   logic                  out_ovf;
   logic                  mult_valid;
   logic signed [DW-1:0]  mult_a;
   logic signed [DW-1:0]  mult_b;
   logic [2*DW-1:0]       mult_result;
   logic                  mult_result_valid;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   exp_taylor_sequencer #(
      .DATA_WIDTH (DW),
      .FRACTION   (FR),
      .TERMS      (TM),
      .PIPE       (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_x              (in_x),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_y             (out_y),
      .out_ovf           (out_ovf),
      .mult_valid        (mult_valid),
      .mult_a            (mult_a),
      .mult_b            (mult_b),
      .mult_result       (mult_result),
      .mult_result_valid (mult_result_valid)
   );

   // Multiplier model: result appears lat cycles after the issue cycle.
   int              lat = 4;
   logic            spur_v = 1'b0;
   logic [2*DW-1:0] spur_r = '0;
   logic            vp [8];
   logic [2*DW-1:0] rp [8];

   always @(posedge clk) begin
      vp[0] <= mult_valid;
      rp[0] <= {{DW{mult_a[DW-1]}}, mult_a} * {{DW{mult_b[DW-1]}}, mult_b};
      for (int i = 1; i < 8; i++) begin
         vp[i] <= vp[i-1];
         rp[i] <= rp[i-1];
      end
   end

   assign mult_result_valid = vp[lat-1] | spur_v;
   assign mult_result       = spur_v ? spur_r : rp[lat-1];

   int mv_pulses = 0;
   int ab_bad = 0;
   always @(negedge clk) begin
      if (mult_valid) mv_pulses <= mv_pulses + 1;
      else if (mult_a != '0 || mult_b != '0) ab_bad <= ab_bad + 1;
   end

   // Reference: plain integer evaluation of the truncated, saturated series.
   function automatic int sat(input int v, inout int ovf);
      if (v > 2047) begin ovf = 1; return 2047; end
      if (v < -2048) begin ovf = 1; return -2048; end
      return v;
   endfunction

   function automatic void ref_exp(input int x, output int y, output int ovf);
      int one, fact, pow, acc, t;
      int recip [TM+1];
      one  = sat(1 << FR, ovf);
      fact = 1;
      for (int n = 1; n <= TM; n++) begin
         fact     = fact * n;
         recip[n] = (1 << FR) / fact;
         if (recip[n] > 2047) recip[n] = 2047;
      end
      ovf = 0;
      pow = one;
      acc = one;
      for (int n = 1; n <= TM; n++) begin
         pow = sat((pow * x) >>> FR, ovf);
         t   = sat((pow * recip[n]) >>> FR, ovf);
         acc = sat(acc + t, ovf);
      end
      y = acc;
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_zero_outs(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 0);
      check({tag, "_out_valid"}, 32'(out_valid), 0);
      check({tag, "_out_y"}, 32'(out_y), 0);
      check({tag, "_out_ovf"}, 32'(out_ovf), 0);
      check({tag, "_mult_valid"}, 32'(mult_valid), 0);
      check({tag, "_mult_a"}, 32'(mult_a), 0);
      check({tag, "_mult_b"}, 32'(mult_b), 0);
   endtask

   task automatic wait_ready(output int ok);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (in_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Presents x for one edge; returns at the negedge of cycle 1 (accept = cycle 0).
   task automatic launch(input logic signed [DW-1:0] x);
      in_x     = x;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_x     = '0;
   endtask

   task automatic wait_out(output int k);
      k = 1;
      while (!out_valid && k < 1000) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic run_op(input string tag, input logic signed [DW-1:0] x,
                         input int y_exp, input int ovf_exp);
      int ok, k, p0;
      wait_ready(ok);
      check({tag, "_ready"}, ok, 1);
      p0 = mv_pulses;
      launch(x);
      wait_out(k);
      check({tag, "_latency"}, k, 1 + 2 * TM * (lat + 1));
      check({tag, "_out_valid"}, 32'(out_valid), 1);
      check({tag, "_out_y"}, 32'(out_y), y_exp);
      check({tag, "_out_ovf"}, 32'(out_ovf), ovf_exp);
      check({tag, "_mult_pulses"}, mv_pulses - p0, 2 * TM);
      @(negedge clk);
      check({tag, "_back_idle"}, 32'(in_ready), 1);
   endtask

   task automatic set_lat(input int l);
      repeat (10) @(negedge clk);
      lat = l;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      int ok, k, y, o;
      logic signed [DW-1:0] rx;

      // Reset state
      repeat (10) @(negedge clk);
      check_zero_outs("reset");
      rst = 1'b0;
      #1;
      check("release_no_edge_in_ready", 32'(in_ready), 0);
      @(negedge clk);
      check("release_in_ready", 32'(in_ready), 1);

      // Directed values
      run_op("x0", 12'sd0, 512, 0);
      run_op("x1", 12'sd512, 1386, 0);
      run_op("xm1", -12'sd512, 192, 0);
      run_op("x3", 12'sd1536, 2047, 1);
      run_op("x0_after_ovf", 12'sd0, 512, 0);

      // Output stall: result held, input and stray results ignored
      out_ready = 1'b0;
      wait_ready(ok);
      check("stall_ready", ok, 1);
      launch(-12'sd512);
      wait_out(k);
      check("stall_latency", k, 41);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         in_x     = 12'sd1536;
         spur_v   = (i % 3 == 0);
         spur_r   = 24'h000fff;
         @(negedge clk);
         check("stall_out_valid", 32'(out_valid), 1);
         check("stall_out_y", 32'(out_y), 192);
         check("stall_out_ovf", 32'(out_ovf), 0);
         check("stall_in_ready", 32'(in_ready), 0);
         check("stall_mult_valid", 32'(mult_valid), 0);
      end
      in_valid  = 1'b0;
      spur_v    = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_release_in_ready", 32'(in_ready), 1);
      check("stall_release_out_valid", 32'(out_valid), 0);

      // Asynchronous reset in the middle of WAIT_TERM (cycle 8 after accept)
      wait_ready(ok);
      launch(12'sd512);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      check_zero_outs("async_rst");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_release_no_edge", 32'(in_ready), 0);
      @(negedge clk);
      check("rst_release_in_ready", 32'(in_ready), 1);
      spur_v = 1'b1;
      spur_r = 24'h00aaaa;
      @(negedge clk);
      spur_v = 1'b0;
      repeat (3) @(negedge clk);
      check("stale_in_ready", 32'(in_ready), 1);
      check("stale_out_valid", 32'(out_valid), 0);
      check("stale_mult_valid", 32'(mult_valid), 0);
      run_op("after_rst_x0", 12'sd0, 512, 0);

      // Shorter multiplier latency
      set_lat(1);
      run_op("lat1_x1", 12'sd512, 1386, 0);

      // Randomized operands and latencies against the reference
      for (int i = 0; i < 16; i++) begin
         set_lat(int'($urandom_range(1, 6)));
         if (i % 2 == 0) rx = DW'($urandom);
         else rx = DW'(int'($urandom_range(0, 1535)) - 768);
         ref_exp(int'(rx), y, o);
         run_op("rand", rx, y, o);
      end

      check("mult_ab_zero_when_idle", ab_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
